ok_wireout_framer: RTL and testbench

- Transmit-side counterpart of the host-to-FPGA trigger parser.
- Collects {endpoint address, data byte} pairs from FPGA logic in a small FIFO.
- Serialises them as a framed 16-bit word stream toward the host: upload header, length word, payload words, XOR checksum.
- Sits between MCU-side endpoint producers and the 16-bit host link arbiter.

---
 rtl/ok_wireout_framer.sv | 177 +++++++++++++++++
 tb/tb_ok_wireout_framer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ok_wireout_framer.sv
// ============================================================================
// Module  : ok_wireout_framer
// Brief   : Buffers {addr,data} entries and sends them to the host as framed
//           16-bit words: header, length, payload, XOR checksum.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ok_wireout_framer #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          MAX_WORDS  = 8,
    parameter int          TIMEOUT    = 1024,
    parameter logic [15:0] UPHEADER   = 16'hB79E
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        ep_valid,
    input  logic [7:0]  ep_addr,
    input  logic [7:0]  ep_data,
    input  logic        flush,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    output logic [2:0]  STATE,
    output logic        frame_done,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HEADER   = 3'd1;
    localparam logic [2:0] S_LENGTH   = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_CHECKSUM = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_remain;
    logic [15:0]   r_chk;
    logic          r_len_ovf;
    logic          r_overflow;
    logic [TW-1:0] r_to_cnt;

    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_accept;
    logic          w_pop;
    logic          w_nonempty;
    logic          w_to_hit;
    logic          w_trigger;
    logic [LW-1:0] w_len_next;
    logic [15:0]   w_head;
    logic [7:0]    w_len8;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_push     = ep_valid && !w_full;
    assign w_drop     = ep_valid && w_full;
    assign w_accept   = tx_valid && tx_ready;
    assign w_pop      = (r_state == S_PAYLOAD) && w_accept;
    assign w_nonempty = (r_count != '0);
    // Counter compares one early so the header shows exactly TIMEOUT cycles after the first push.
    assign w_to_hit   = (TIMEOUT != 0) && (r_to_cnt == TW'(TIMEOUT - 1));
    assign w_trigger  = (r_state == S_IDLE) && w_nonempty &&
                        (flush || (r_count >= CW'(MAX_WORDS)) || w_to_hit);
    assign w_len_next = (r_count >= CW'(MAX_WORDS)) ? LW'(MAX_WORDS) : LW'(r_count);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_len8     = 8'(r_len);

    assign tx_valid   = (r_state == S_HEADER) || (r_state == S_LENGTH) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CHECKSUM);
    assign frame_done = (r_state == S_DONE);
    assign STATE      = r_state;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;

    always_comb begin
        tx_data = 16'h0000;
        case (r_state)
            S_HEADER:   tx_data = UPHEADER;
            S_LENGTH:   tx_data = {r_len_ovf, 7'b0, w_len8};
            S_PAYLOAD:  tx_data = w_head;
            S_CHECKSUM: tx_data = r_chk;
            default:    tx_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {ep_addr, ep_data};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_remain   <= '0;
            r_chk      <= 16'h0000;
            r_len_ovf  <= 1'b0;
            r_overflow <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A drop in the trigger cycle re-arms the flag for the next frame.
            if (w_trigger) begin
                r_overflow <= w_drop;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (!w_nonempty || w_trigger) begin
                r_to_cnt <= '0;
            end else if (r_state == S_IDLE) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_state   <= S_HEADER;
                        r_len     <= w_len_next;
                        r_remain  <= w_len_next;
                        r_chk     <= 16'h0000;
                        r_len_ovf <= r_overflow;
                    end
                end
                S_HEADER: begin
                    if (w_accept) r_state <= S_LENGTH;
                end
                S_LENGTH: begin
                    if (w_accept) r_state <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (w_accept) begin
                        r_chk    <= r_chk ^ w_head;
                        r_remain <= r_remain - LW'(1);
                        if (r_remain == LW'(1)) begin
                            r_state <= S_CHECKSUM;
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (w_accept) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ok_wireout_framer.sv
// ============================================================================
// Module  : tb_ok_wireout_framer
// Brief   : Directed and randomized checks of ok_wireout_framer against a
//           frame-level queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ok_wireout_framer;

    localparam int          FD  = 16;
    localparam int          MW  = 8;
    localparam int          TO  = 1024;
    localparam logic [15:0] UPH = 16'hB79E;

    logic        clk_in = 1'b0;
    logic        rst, ep_valid, flush, tx_ready;
    logic [7:0]  ep_addr, ep_data;
    logic [15:0] tx_data;
    logic        tx_valid, frame_done, fifo_full, overflow;
    logic [2:0]  STATE;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending entries, words still to send in the current frame.
    logic [15:0] mq[$];
    logic [15:0] mw[$];
    logic [15:0] got[$];
    int          mlen, msent, mto;
    logic        mdone, movf;

    always #5 clk_in = ~clk_in;

    ok_wireout_framer #(
        .FIFO_DEPTH(FD), .MAX_WORDS(MW), .TIMEOUT(TO), .UPHEADER(UPH)
    ) dut (
        .clk_in(clk_in), .rst(rst), .ep_valid(ep_valid), .ep_addr(ep_addr),
        .ep_data(ep_data), .flush(flush), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .STATE(STATE),
        .frame_done(frame_done), .fifo_full(fifo_full), .overflow(overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int pre, l;
        bit full, push, drop, trig;
        logic [15:0] c;
        if (rst) begin
            mq.delete(); mw.delete();
            mdone = 0; movf = 0; mto = 0;
            return;
        end
        pre  = mq.size();
        full = (pre == FD);
        push = ep_valid && !full;
        drop = ep_valid && full;
        if (mw.size() > 0) begin
            if (tx_ready) begin
                if (msent >= 2 && msent < 2 + mlen) void'(mq.pop_front());
                void'(mw.pop_front());
                msent++;
                if (mw.size() == 0) mdone = 1;
            end
            if (pre == 0) mto = 0;
        end else if (mdone) begin
            mdone = 0;
            if (pre == 0) mto = 0;
        end else begin
            trig = (pre > 0) && (flush || pre >= MW || (TO != 0 && mto == TO - 1));
            if (trig) begin
                l = (pre < MW) ? pre : MW;
                c = 16'h0000;
                mw.push_back(UPH);
                mw.push_back({movf, 7'b0, 8'(l)});
                for (int i = 0; i < l; i++) begin
                    mw.push_back(mq[i]);
                    c = c ^ mq[i];
                end
                mw.push_back(c);
                mlen = l; msent = 0; movf = 0; mto = 0;
            end else if (pre == 0) begin
                mto = 0;
            end else begin
                mto++;
            end
        end
        if (drop) movf = 1;
        if (push) mq.push_back({ep_addr, ep_data});
    endtask

    function automatic int exp_state();
        int sz;
        sz = mw.size();
        if (sz > 0) begin
            if (sz == mlen + 3) return 1;
            if (sz == mlen + 2) return 2;
            if (sz == 1) return 4;
            return 3;
        end
        return mdone ? 5 : 0;
    endfunction

    task automatic check_outputs();
        check_eq("tx_valid", 32'(tx_valid), 32'(mw.size() > 0));
        if (mw.size() > 0) check_eq("tx_data", 32'(tx_data), 32'(mw[0]));
        check_eq("state", 32'(STATE), 32'(exp_state()));
        check_eq("frame_done", 32'(frame_done), 32'(mdone));
        check_eq("fifo_full", 32'(fifo_full), 32'(mq.size() == FD));
        check_eq("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic tick();
        if (tx_valid && tx_ready && !rst) got.push_back(tx_data);
        model_step();
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        ep_valid = 1; ep_addr = a; ep_data = d;
        tick();
        ep_valid = 0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        tx_ready = 1; ep_valid = 0;
        while ((mw.size() > 0 || mdone || mq.size() > 0) && n < bound) begin
            flush = (mq.size() > 0) && (mw.size() == 0) && !mdone;
            tick();
            n++;
        end
        flush = 0;
        check_eq("drain_bound", 32'(n < bound), 32'd1);
    endtask

    task automatic check_two_entry_frame(input string tag);
        logic [15:0] exp_w [5];
        exp_w[0] = 16'hB79E; exp_w[1] = 16'h0002; exp_w[2] = 16'h01AA;
        exp_w[3] = 16'h0255; exp_w[4] = 16'h03FF;
        check_eq({tag, "_count"}, 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) check_eq(tag, 32'(got[i]), 32'(exp_w[i]));
    endtask

    initial begin
        int n;
        rst = 1; ep_valid = 0; ep_addr = 0; ep_data = 0; flush = 0; tx_ready = 0;
        mlen = 0; msent = 0; mto = 0; mdone = 0; movf = 0;
        tick(); tick();
        check_eq("reset_tx_data", 32'(tx_data), 32'h0);
        rst = 0;

        // Two-entry frame with flush
        got.delete();
        tx_ready = 1;
        push(8'h01, 8'hAA);
        push(8'h02, 8'h55);
        flush = 1; tick(); flush = 0;
        drain(100);
        check_two_entry_frame("basic");

        // Same frame with tx_ready toggling every cycle
        got.delete();
        tx_ready = 0;
        push(8'h01, 8'hAA);
        push(8'h02, 8'h55);
        flush = 1; tick(); flush = 0;
        n = 0;
        while ((mw.size() > 0 || mdone) && n < 200) begin
            tx_ready = ~tx_ready;
            tick();
            n++;
        end
        check_eq("toggle_bound", 32'(n < 200), 32'd1);
        check_two_entry_frame("toggle");

        // Nine entries: auto frame of 8, then a frame of 1
        got.delete();
        tx_ready = 1;
        for (int i = 0; i < 9; i++) push(8'(i + 16), 8'($urandom));
        drain(3000);
        check_eq("auto_len", 32'(got.size() > 12 ? got[1] : 16'hxxxx), 32'h0008);
        check_eq("rest_len", 32'(got.size() > 12 ? got[12] : 16'hxxxx), 32'h0001);

        // Fill past capacity while the link is stalled
        got.delete();
        tx_ready = 0;
        for (int i = 0; i < 20; i++) push(8'(i), 8'(i * 3));
        check_eq("full_flag", 32'(fifo_full), 32'd1);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        drain(3000);
        check_eq("ovf_len", 32'(got.size() > 12 ? got[12] : 16'hxxxx), 32'h8008);
        check_eq("ovf_cleared", 32'(overflow), 32'd0);

        // Timeout latency for a lone entry, then flush on empty FIFO
        tx_ready = 1;
        push(8'h7E, 8'h11);
        n = 0;
        while (!tx_valid && n < 2000) begin tick(); n++; end
        check_eq("timeout_latency", 32'(n), 32'd1024);
        drain(100);
        flush = 1; tick(); flush = 0;
        check_eq("empty_flush", 32'(tx_valid), 32'd0);
        tick();
        check_eq("empty_flush2", 32'(tx_valid), 32'd0);

        // Reset in the middle of the payload
        push(8'hA0, 8'h01); push(8'hA1, 8'h02); push(8'hA2, 8'h03);
        flush = 1; tick(); flush = 0;
        n = 0;
        while (STATE != 3'd3 && n < 20) begin tick(); n++; end
        check_eq("reach_payload", 32'(STATE), 32'd3);
        rst = 1; tick(); rst = 0;
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_state", 32'(STATE), 32'd0);
        check_eq("rst_full", 32'(fifo_full), 32'd0);
        flush = 1; tick(); flush = 0; tick();
        check_eq("rst_flush", 32'(tx_valid), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            ep_valid = ($urandom_range(0, 99) < 40);
            ep_addr  = 8'($urandom);
            ep_data  = 8'($urandom);
            flush    = ($urandom_range(0, 99) < 5);
            tx_ready = ($urandom_range(0, 99) < 70);
            rst      = ($urandom_range(0, 999) < 2);
            tick();
        end
        rst = 0; ep_valid = 0; flush = 0;
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
